south_port_arbiter: RTL and testbench

Round-robin arbiter that shares the router's single south output link among several requesters (north-input forwarding path, east, west and local injection). Each requester has a one-entry holding register. A registered output stage drives the link with a valid/ready handshake. Packets pass through unmodified; dy decrement and local ejection stay in the forwarding stage downstream of this block.

---
 rtl/south_port_arbiter_if.sv | 23 ++
 rtl/south_port_arbiter.sv | 69 ++++++
 tb/tb_south_port_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/south_port_arbiter_if.sv
// south_port_arbiter_if: requester holding-register inputs and south link handshake bundle
interface south_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 16,
  parameter int GID_W = $clog2(NUM_REQ)
);
  logic [NUM_REQ*WIDTH-1:0] req_packet;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [WIDTH-1:0] out_packet;
  logic out_valid;
  logic out_ready;
  logic [GID_W-1:0] out_src;
  logic [15:0] pkt_count;
  modport slave(
    input req_packet, req_valid, out_ready,
    output req_ready, out_packet, out_valid, out_src, pkt_count
  );
  modport master(
    output req_packet, req_valid, out_ready,
    input req_ready, out_packet, out_valid, out_src, pkt_count
  );
endinterface

// File: rtl/south_port_arbiter.sv
// south_port_arbiter: round-robin share of the south link among one-entry requester holds
module south_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 16,
  parameter int GID_W = $clog2(NUM_REQ)
) (
  input logic clk,
  input logic rst,
  south_port_arbiter_if.slave bus
);
  logic [NUM_REQ-1:0] hold_valid;
  logic [WIDTH-1:0] hold_pkt [NUM_REQ];
  logic [GID_W-1:0] rr_ptr;
  logic [GID_W-1:0] win;
  logic [GID_W-1:0] win_nxt;
  logic [GID_W:0] idx;
  logic out_valid;
  logic [WIDTH-1:0] out_packet;
  logic [GID_W-1:0] out_src;
  logic [15:0] pkt_count;
  logic out_free;
  logic any_hold;
  assign out_free = ~out_valid | bus.out_ready;
  assign any_hold = |hold_valid;
  assign win_nxt = win == GID_W'(NUM_REQ - 1) ? '0 : win + 1'b1;
  assign bus.req_ready = ~hold_valid;
  assign bus.out_valid = out_valid;
  assign bus.out_packet = out_packet;
  assign bus.out_src = out_src;
  assign bus.pkt_count = pkt_count;
  // scan from the farthest offset back toward rr_ptr so the nearest set hold wins
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (GID_W+1)'(k);
      idx = idx >= (GID_W+1)'(NUM_REQ) ? idx - (GID_W+1)'(NUM_REQ) : idx;
      win = hold_valid[idx[GID_W-1:0]] ? idx[GID_W-1:0] : win;
    end
  end
  // capture into empty holds, move the winner to the output register when the slot frees
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) hold_pkt[i] <= '0;
      rr_ptr <= '0;
      out_valid <= 1'b0;
      out_packet <= '0;
      out_src <= '0;
      pkt_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.req_valid[i] && !hold_valid[i]) begin
          hold_valid[i] <= 1'b1;
          hold_pkt[i] <= bus.req_packet[i*WIDTH +: WIDTH];
        end
      if (out_free) begin
        out_valid <= any_hold;
        if (any_hold) begin
          out_packet <= hold_pkt[win];
          out_src <= win;
          hold_valid[win] <= 1'b0;
          rr_ptr <= win_nxt;
        end
      end
      if (out_valid && bus.out_ready) pkt_count <= pkt_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_south_port_arbiter.sv
// tb_south_port_arbiter: directed checks of arbitration order, backpressure, wrap and reset
module tb_south_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  south_port_arbiter_if bus();
  south_port_arbiter dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  task automatic set_pkt(input int i, input logic [15:0] p);
    bus.req_packet[i*16 +: 16] = p;
  endtask
  initial begin
    int n;
    bus.req_packet = '0;
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", 32'(bus.req_ready), 32'hF);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_pkt", 32'(bus.out_packet), 0);
    chk("rst_src", 32'(bus.out_src), 0);
    chk("rst_cnt", 32'(bus.pkt_count), 0);
    set_pkt(3, 16'h0320);
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid = '0;
    chk("single_ready_low", 32'(bus.req_ready), 32'h7);
    chk("single_not_yet", 32'(bus.out_valid), 0);
    tick();
    chk("single_valid", 32'(bus.out_valid), 1);
    chk("single_pkt", 32'(bus.out_packet), 32'h0320);
    chk("single_src", 32'(bus.out_src), 3);
    chk("single_ready_back", 32'(bus.req_ready), 32'hF);
    chk("single_cnt0", 32'(bus.pkt_count), 0);
    tick();
    chk("single_drained", 32'(bus.out_valid), 0);
    chk("single_cnt1", 32'(bus.pkt_count), 1);
    set_pkt(0, 16'h1100);
    set_pkt(1, 16'h2200);
    set_pkt(2, 16'h3300);
    set_pkt(3, 16'h4400);
    bus.req_valid = 4'hF;
    tick();
    bus.req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr0_valid", 32'(bus.out_valid), 1);
      chk("rr0_src", 32'(bus.out_src), 32'(k));
      chk("rr0_pkt", 32'(bus.out_packet), 32'((k + 1) * 32'h1100));
    end
    tick();
    chk("rr0_drained", 32'(bus.out_valid), 0);
    chk("rr0_cnt", 32'(bus.pkt_count), 5);
    set_pkt(1, 16'h0001);
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    tick();
    chk("ptr_set_src", 32'(bus.out_src), 1);
    tick();
    set_pkt(1, 16'h2200);
    bus.req_valid = 4'hF;
    tick();
    bus.req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr2_src", 32'(bus.out_src), 32'((k + 2) % 4));
      chk("rr2_pkt", 32'(bus.out_packet), 32'(((k + 2) % 4 + 1) * 32'h1100));
    end
    tick();
    chk("rr2_cnt", 32'(bus.pkt_count), 10);
    bus.out_ready = 1'b0;
    set_pkt(0, 16'hA0A0);
    set_pkt(3, 16'hD0D0);
    bus.req_valid = 4'b1001;
    tick();
    bus.req_valid = '0;
    tick();
    chk("bp_src", 32'(bus.out_src), 3);
    chk("bp_pkt", 32'(bus.out_packet), 32'hD0D0);
    set_pkt(3, 16'hE0E0);
    bus.req_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      tick();
      bus.req_valid = '0;
      chk("bp_hold_valid", 32'(bus.out_valid), 1);
      chk("bp_hold_pkt", 32'(bus.out_packet), 32'hD0D0);
      chk("bp_hold_src", 32'(bus.out_src), 3);
      chk("bp_hold_cnt", 32'(bus.pkt_count), 10);
    end
    chk("bp_ready", 32'(bus.req_ready), 32'h6);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_rel_src", 32'(bus.out_src), 0);
    chk("bp_rel_pkt", 32'(bus.out_packet), 32'hA0A0);
    chk("bp_rel_cnt", 32'(bus.pkt_count), 11);
    tick();
    chk("bp_refill_src", 32'(bus.out_src), 3);
    chk("bp_refill_pkt", 32'(bus.out_packet), 32'hE0E0);
    tick();
    chk("bp_drained", 32'(bus.out_valid), 0);
    chk("bp_cnt", 32'(bus.pkt_count), 13);
    set_pkt(0, 16'h00AA);
    set_pkt(1, 16'h00BB);
    bus.req_valid = 4'b0011;
    tick();
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("sat_valid", 32'(bus.out_valid), 1);
      chk("sat_src", 32'(bus.out_src), 32'(k % 2));
      chk("sat_pkt", 32'(bus.out_packet), (k % 2) == 0 ? 32'h00AA : 32'h00BB);
    end
    bus.req_valid = '0;
    tick();
    chk("sat_last_src", 32'(bus.out_src), 0);
    tick();
    chk("sat_drained", 32'(bus.out_valid), 0);
    chk("sat_cnt", 32'(bus.pkt_count), 34);
    bus.req_valid = 4'b0011;
    n = 0;
    while (bus.pkt_count != 16'hFFFF && n < 70000) begin
      tick();
      n++;
    end
    bus.req_valid = '0;
    bus.out_ready = 1'b0;
    chk("wrap_reached", 32'(n < 70000), 1);
    chk("wrap_pre", 32'(bus.pkt_count), 32'hFFFF);
    chk("wrap_inflight", 32'(bus.out_valid), 1);
    tick();
    chk("wrap_frozen", 32'(bus.pkt_count), 32'hFFFF);
    bus.out_ready = 1'b1;
    tick();
    chk("wrap_zero", 32'(bus.pkt_count), 0);
    for (int k = 0; k < 6; k++) tick();
    chk("wrap_drained", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;
    set_pkt(0, 16'h5151);
    set_pkt(1, 16'h5252);
    set_pkt(2, 16'h5353);
    set_pkt(3, 16'h5454);
    bus.req_valid = 4'hF;
    tick();
    bus.req_valid = '0;
    tick();
    chk("mid_valid", 32'(bus.out_valid), 1);
    chk("mid_three_full", 32'($countones(bus.req_ready)), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'hF);
    chk("mid_rst_cnt", 32'(bus.pkt_count), 0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_no_ghost", 32'(bus.out_valid), 0);
    end
    chk("mid_cnt_after", 32'(bus.pkt_count), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
